// File: rtl/ltc2600_cmd_sequencer.sv
// Command scheduler for the LTC2600 serial writer: request FIFO, per-channel shadow of the last
// written codes, all-channel sweep from the shadow, one command in flight with a timeout guard.
module ltc2600_cmd_sequencer #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned N_CH           = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [3:0]                    req_command,
  input  logic [3:0]                    req_address,
  input  logic [DATA_WIDTH-1:0]         req_data,
  input  logic                          sweep_start,
  input  logic                          err_clear,
  output logic                          dac_send_new_cmd,
  output logic [3:0]                    dac_command,
  output logic [3:0]                    dac_address,
  output logic [DATA_WIDTH-1:0]         dac_data,
  input  logic                          dac_write_complete,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          timeout_err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned ChW  = $clog2(N_CH);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned EntW = 8 + DATA_WIDTH;
  localparam logic [3:0]  CmdWrite       = 4'h0;
  localparam logic [3:0]  CmdWriteUpdAll = 4'h2;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StGap} state_e;

  // Reset asserts asynchronously but is released on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rst_sync_q <= '0;
    else       rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  state_e                state_q, state_d;
  logic [EntW-1:0]       fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [DATA_WIDTH-1:0] shadow_q [N_CH];
  logic [DATA_WIDTH-1:0] shadow_d [N_CH];
  logic                  sweep_pend_q, sweep_pend_d, sweep_act_q, sweep_act_d;
  logic [ChW-1:0]        ch_q, ch_d, ch_next;
  logic [3:0]            cmd_q, cmd_d, addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ToW-1:0]        wait_cnt_q, wait_cnt_d;
  logic                  timeout_err_q, timeout_err_d;

  logic                  fifo_full, fifo_empty, push, pop, timeout_hit, sweep_more;
  logic [3:0]            head_cmd, head_addr;
  logic [DATA_WIDTH-1:0] head_data;

  assign fifo_full   = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_empty  = (count_q == '0);
  assign push        = req_valid && !fifo_full;
  assign pop         = (state_q == StIdle) && !sweep_pend_q && !fifo_empty;
  assign {head_cmd, head_addr, head_data} = fifo_mem_q[rd_ptr_q];
  assign timeout_hit = (wait_cnt_q == ToW'(TIMEOUT_CYCLES - 1));
  assign sweep_more  = sweep_act_q && (ch_q != ChW'(N_CH - 1));

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {req_command, req_address, req_data};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + CntW'(push) - CntW'(pop);
    shadow_d = shadow_q;
    if (pop && (head_cmd inside {4'h0, 4'h2, 4'h3})) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        if (head_addr == 4'hF || head_addr == 4'(i)) shadow_d[i] = head_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      shadow_q      <= '{default: '0};
      sweep_pend_q  <= 1'b0;
      sweep_act_q   <= 1'b0;
      ch_q          <= '0;
      cmd_q         <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      shadow_q      <= shadow_d;
      sweep_pend_q  <= sweep_pend_d;
      sweep_act_q   <= sweep_act_d;
      ch_q          <= ch_d;
      cmd_q         <= cmd_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (sweep_pend_q || !fifo_empty) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (dac_write_complete || timeout_hit) state_d = StGap;
      StGap:   state_d = sweep_more ? StIssue : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Command registers only load in IDLE and GAP, so they stay frozen through WAIT.
  always_comb begin
    sweep_pend_d  = sweep_pend_q;
    sweep_act_d   = sweep_act_q;
    ch_d          = ch_q;
    ch_next       = ch_q + 1'b1;
    cmd_d         = cmd_q;
    addr_d        = addr_q;
    data_d        = data_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      StIdle: begin
        if (sweep_pend_q) begin
          sweep_pend_d = 1'b0;
          sweep_act_d  = 1'b1;
          ch_d         = '0;
          cmd_d        = CmdWrite;
          addr_d       = 4'h0;
          data_d       = shadow_q[0];
        end else if (!fifo_empty) begin
          cmd_d  = head_cmd;
          addr_d = head_addr;
          data_d = head_data;
        end
      end
      StIssue: wait_cnt_d = '0;
      StWait: begin
        if (!dac_write_complete) begin
          if (timeout_hit) timeout_err_d = 1'b1;
          else             wait_cnt_d    = wait_cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (sweep_more) begin
          ch_d   = ch_next;
          cmd_d  = (ch_next == ChW'(N_CH - 1)) ? CmdWriteUpdAll : CmdWrite;
          addr_d = 4'(ch_next);
          data_d = shadow_q[ch_next];
        end else begin
          sweep_act_d = 1'b0;
        end
      end
      default: ;
    endcase
    if (sweep_start) sweep_pend_d  = 1'b1;
    if (err_clear)   timeout_err_d = 1'b0;
  end

  always_comb begin
    dac_send_new_cmd = (state_q == StIssue);
    dac_command      = cmd_q;
    dac_address      = addr_q;
    dac_data         = data_q;
    busy             = (state_q != StIdle) || !fifo_empty || sweep_pend_q;
    req_ready        = !fifo_full;
    fifo_count       = count_q;
    timeout_err      = timeout_err_q;
  end

endmodule
